// File: rtl/decode_queue_if.sv
// Fetch-side and dispatch-side handshake bundle for decode_queue.
// The master modport drives fetch inputs and downstream ready; the slave is the queue.
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc_in;
  logic             valid_in;
  logic             ready_in;
  logic             ready_out;
  logic             valid_out;
  logic [XLEN-1:0]  pc_out;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd;
  logic [XLEN-1:0]  imm;
  logic [2:0]       ALUOp;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             illegal;
  logic [CW-1:0]    count;

  modport master (
    output flush, instr, pc_in, valid_in, ready_out,
    input  ready_in, valid_out, pc_out, rs1, rs2, rd, imm, ALUOp,
           opcode, funct3, funct7, illegal, count
  );

  modport slave (
    input  flush, instr, pc_in, valid_in, ready_out,
    output ready_in, valid_out, pc_out, rs1, rs2, rd, imm, ALUOp,
           opcode, funct3, funct7, illegal, count
  );
endinterface

// File: rtl/decode_queue.sv
// RV32 decoder feeding a DEPTH-entry FIFO with flush; one decode per cycle.
// Optional DECODE_QUEUE_PERF_EN adds push/stall/illegal event counters.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  decode_queue_if.slave   q
`ifdef DECODE_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_full_stall,
  output logic [31:0]     perf_illegal
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [2:0]       alu_op;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             illegal;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          dec, head;
  logic [31:0]     imm32;
  logic            ready_in, push, pop;

  // NOTE: combinational next-state uses blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.pc     = q.pc_in;
    dec.opcode = q.instr[6:0];
    dec.funct3 = q.instr[14:12];
    dec.funct7 = q.instr[31:25];
    case (q.instr[6:0])
      7'b0010011: begin
        dec.rs1 = REG_W'(q.instr[19:15]); dec.rd = REG_W'(q.instr[11:7]);
        imm32 = {{20{q.instr[31]}}, q.instr[31:20]}; dec.alu_op = 3'b011;
      end
      7'b0110111: begin
        dec.rd = REG_W'(q.instr[11:7]);
        imm32 = {q.instr[31:12], 12'b0}; dec.alu_op = 3'b100;
      end
      7'b0110011: begin
        dec.rs1 = REG_W'(q.instr[19:15]); dec.rs2 = REG_W'(q.instr[24:20]);
        dec.rd = REG_W'(q.instr[11:7]); dec.alu_op = 3'b010;
      end
      7'b0000011: begin
        dec.rs1 = REG_W'(q.instr[19:15]); dec.rd = REG_W'(q.instr[11:7]);
        imm32 = {{20{q.instr[31]}}, q.instr[31:20]}; dec.alu_op = 3'b000;
      end
      7'b0100011: begin
        dec.rs1 = REG_W'(q.instr[19:15]); dec.rs2 = REG_W'(q.instr[24:20]);
        imm32 = {{20{q.instr[31]}}, q.instr[31:25], q.instr[11:7]}; dec.alu_op = 3'b000;
      end
      7'b1100011: begin
        dec.rs1 = REG_W'(q.instr[19:15]); dec.rs2 = REG_W'(q.instr[24:20]);
        imm32 = {{20{q.instr[31]}}, q.instr[7], q.instr[30:25], q.instr[11:8], 1'b0};
        dec.alu_op = 3'b001;
      end
      7'b1100111: begin
        dec.rs1 = REG_W'(q.instr[19:15]); dec.rd = REG_W'(q.instr[11:7]);
        imm32 = {{20{q.instr[31]}}, q.instr[31:20]}; dec.alu_op = 3'b110;
      end
      7'b1101111: begin
        dec.rd = REG_W'(q.instr[11:7]);
        imm32 = {{12{q.instr[31]}}, q.instr[19:12], q.instr[20], q.instr[30:21], 1'b0};
        dec.alu_op = 3'b101;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  // Full queue still accepts when the head leaves this cycle (ready_out -> ready_in path).
  assign ready_in = !q.flush && ((count_q < FULL) || q.ready_out);
  assign push     = q.valid_in && ready_in;
  assign pop      = (count_q != '0) && q.ready_out;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = dec;
        tail_d        = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is reset too, so the head slot reads as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head = (count_q != '0) ? mem_q[head_q] : '0;
    q.ready_in  = ready_in;
    q.valid_out = (count_q != '0);
    q.count     = count_q;
    q.pc_out    = head.pc;
    q.rs1       = head.rs1;
    q.rs2       = head.rs2;
    q.rd        = head.rd;
    q.imm       = head.imm;
    q.ALUOp     = head.alu_op;
    q.opcode    = head.opcode;
    q.funct3    = head.funct3;
    q.funct7    = head.funct7;
    q.illegal   = head.illegal;
  end

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] perf_dec_q, perf_dec_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_ill_q, perf_ill_d;

  // Counters survive flush; they only clear on reset.
  always_comb begin
    perf_dec_d   = perf_dec_q + 32'(push);
    perf_ill_d   = perf_ill_q + 32'(push && dec.illegal);
    perf_stall_d = perf_stall_q + 32'(q.valid_in && !ready_in && !q.flush);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_dec_q   <= '0;
      perf_stall_q <= '0;
      perf_ill_q   <= '0;
    end else begin
      perf_dec_q   <= perf_dec_d;
      perf_stall_q <= perf_stall_d;
      perf_ill_q   <= perf_ill_d;
    end
  end

  assign perf_decoded    = perf_dec_q;
  assign perf_full_stall = perf_stall_q;
  assign perf_illegal    = perf_ill_q;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: driver pushes expected entries on acceptance,
// a negedge monitor compares the head and handshake against a reference occupancy.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) q ();

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] perf_decoded, perf_full_stall, perf_illegal;
  int unsigned m_dec, m_stall, m_ill;
`endif

  decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
`ifdef DECODE_QUEUE_PERF_EN
    ,
    .perf_decoded    (perf_decoded),
    .perf_full_stall (perf_full_stall),
    .perf_illegal    (perf_illegal)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  alu;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
  } vec_t;

  vec_t vecs [11];
  vec_t cur;
  vec_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   last_acc = 1'b0;

  function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc, logic [4:0] rs1,
                              logic [4:0] rs2, logic [4:0] rd, logic [31:0] imm,
                              logic [2:0] alu, logic [6:0] opc, logic [2:0] f3,
                              logic [6:0] f7, logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
    v.alu = alu; v.opc = opc; v.f3 = f3; v.f7 = f7; v.ill = ill;
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reference occupancy is sb.size(); head compared every cycle it is valid.
  always @(negedge clk) begin
    bit exp_ready;
    bit do_pop;
    if (reset) begin
      sb.delete();
      last_acc = 1'b0;
      check("rst_valid_out", q.valid_out, 0);
      check("rst_count", q.count, 0);
`ifdef DECODE_QUEUE_PERF_EN
      m_dec = 0; m_stall = 0; m_ill = 0;
`endif
    end else begin
      exp_ready = !q.flush && ((sb.size() < DEPTH) || q.ready_out);
      check("ready_in", q.ready_in, exp_ready);
      check("valid_out", q.valid_out, sb.size() != 0);
      check("count", q.count, sb.size());
`ifdef DECODE_QUEUE_PERF_EN
      check("perf_decoded", perf_decoded, m_dec);
      check("perf_full_stall", perf_full_stall, m_stall);
      check("perf_illegal", perf_illegal, m_ill);
`endif
      do_pop = 1'b0;
      if (sb.size() == 0) begin
        check("empty_outputs_zero", {q.pc_out, q.rs1, q.rs2, q.rd, q.imm, q.ALUOp,
              q.opcode, q.funct3, q.funct7, q.illegal}, '0);
      end else begin
        check("pc_out", q.pc_out, sb[0].pc);
        check("rs1", q.rs1, sb[0].rs1);
        check("rs2", q.rs2, sb[0].rs2);
        check("rd", q.rd, sb[0].rd);
        check("imm", q.imm, sb[0].imm);
        check("ALUOp", q.ALUOp, sb[0].alu);
        check("opcode", q.opcode, sb[0].opc);
        check("funct3", q.funct3, sb[0].f3);
        check("funct7", q.funct7, sb[0].f7);
        check("illegal", q.illegal, sb[0].ill);
        do_pop = q.ready_out;
      end
      last_acc = q.valid_in && exp_ready;
`ifdef DECODE_QUEUE_PERF_EN
      if (last_acc) m_dec++;
      if (last_acc && cur.ill) m_ill++;
      if (q.valid_in && !exp_ready && !q.flush) m_stall++;
`endif
      if (q.flush) sb.delete();
      else begin
        if (do_pop) void'(sb.pop_front());
        if (last_acc) sb.push_back(cur);
      end
    end
  end

  task automatic present(int idx);
    cur        = vecs[idx];
    q.instr    = cur.instr;
    q.pc_in    = cur.pc;
    q.valid_in = 1'b1;
  endtask

  task automatic send(int idx);
    present(idx);
    for (int n = 0; n <= 40; n++) begin
      @(posedge clk);
      if (last_acc) break;
      if (n == 40) check("send_timeout", last_acc, 1);
    end
    #1 q.valid_in = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(32'h00510093, 32'h1000, 5'd2, 5'd0, 5'd1, 32'h00000005, 3'b011, 7'h13, 3'd0, 7'h00, 1'b0);
    vecs[1]  = mk(32'hFFF00093, 32'h1004, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 3'b011, 7'h13, 3'd0, 7'h7F, 1'b0);
    vecs[2]  = mk(32'h123452B7, 32'h1008, 5'd0, 5'd0, 5'd5, 32'h12345000, 3'b100, 7'h37, 3'd5, 7'h09, 1'b0);
    vecs[3]  = mk(32'h002081B3, 32'h100C, 5'd1, 5'd2, 5'd3, 32'h00000000, 3'b010, 7'h33, 3'd0, 7'h00, 1'b0);
    vecs[4]  = mk(32'h407302B3, 32'h1010, 5'd6, 5'd7, 5'd5, 32'h00000000, 3'b010, 7'h33, 3'd0, 7'h20, 1'b0);
    vecs[5]  = mk(32'h00812203, 32'h1014, 5'd2, 5'd0, 5'd4, 32'h00000008, 3'b000, 7'h03, 3'd2, 7'h00, 1'b0);
    vecs[6]  = mk(32'hFE512E23, 32'h1018, 5'd2, 5'd5, 5'd0, 32'hFFFFFFFC, 3'b000, 7'h23, 3'd2, 7'h7F, 1'b0);
    vecs[7]  = mk(32'hFE208CE3, 32'h101C, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 3'b001, 7'h63, 3'd0, 7'h7F, 1'b0);
    vecs[8]  = mk(32'h004280E7, 32'h1020, 5'd5, 5'd0, 5'd1, 32'h00000004, 3'b110, 7'h67, 3'd0, 7'h00, 1'b0);
    vecs[9]  = mk(32'h001000EF, 32'h1024, 5'd0, 5'd0, 5'd1, 32'h00000800, 3'b101, 7'h6F, 3'd0, 7'h00, 1'b0);
    vecs[10] = mk(32'hFFFFFFFF, 32'h1028, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'b000, 7'h7F, 3'd7, 7'h7F, 1'b1);
    cur = vecs[0];

    reset = 1'b1; q.flush = 1'b0; q.valid_in = 1'b0; q.ready_out = 1'b1;
    q.instr = '0; q.pc_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Single addi into an empty queue, then back-to-back stream of every opcode class.
    send(0);
    idle(3);
    for (int i = 1; i <= 10; i++) send(i);
    idle(3);

    // Fill with ready_out low; 5th waits for the same-cycle pop.
    q.ready_out = 1'b0;
    for (int i = 0; i < 4; i++) send(i);
    fork
      send(4);
      begin idle(3); q.ready_out = 1'b1; end
    join
    idle(8);

    // Flush with a valid input presented: nothing accepted, queue empties.
    q.ready_out = 1'b0;
    send(5); send(6); send(7);
    present(8);
    q.flush = 1'b1;
    idle(1);
    q.flush = 1'b0; q.valid_in = 1'b0;
    idle(2);
    q.ready_out = 1'b1;
    idle(3);

    // Asynchronous reset between edges with two entries queued.
    q.ready_out = 1'b0;
    send(1); send(10);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_valid_out", q.valid_out, 0);
    check("async_count", q.count, 0);
`ifdef DECODE_QUEUE_PERF_EN
    check("async_perf_decoded", perf_decoded, 0);
    check("async_perf_full_stall", perf_full_stall, 0);
    check("async_perf_illegal", perf_illegal, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0; q.ready_out = 1'b1;
    send(2);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-entry decode stage.
- Decodes one RV32 instruction per cycle (fields, immediate, ALUOp, illegal flag) and pushes the result into a DEPTH-entry FIFO.
- The FIFO absorbs downstream stalls without bubbles and supports a synchronous flush for branch mispredict recovery.
- Sits between fetch and rename/dispatch; uses the same valid/ready handshake on both sides.

Parameters:
- DEPTH, 4, number of decoded-entry slots; power of two, >= 2.
- XLEN, 32, width of pc and imm.
- REG_W, 5, register index width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all queued entries.
- instr  input  32  raw instruction.
- pc_in  input  XLEN  pc of instr.
- valid_in  input  1  upstream valid.
- ready_in  output  1  upstream ready.
- ready_out  input  1  downstream ready.
- valid_out  output  1  head entry valid.
- pc_out  output  XLEN  head pc.
- rs1  output  REG_W  head source 1.
- rs2  output  REG_W  head source 2.
- rd  output  REG_W  head destination.
- imm  output  XLEN  head sign-extended immediate.
- ALUOp  output  3  head ALU class.
- opcode  output  7  head opcode.
- funct3  output  3  head instr[14:12].
- funct7  output  7  head instr[31:25].
- illegal  output  1  head opcode unrecognised.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - On reset: count=0, head/tail pointers=0, all storage zeroed, valid_out=0, all data outputs 0, ready_in=1.
- Decode (combinational, from instr):
  - 0010011 I-type: rs1 used, rd used, I-imm, ALUOp 011.
  - 0110111 LUI: rd used, U-imm, ALUOp 100.
  - 0110011 R-type: rs1, rs2, rd used, imm 0, ALUOp 010.
  - 0000011 load: rs1, rd used, I-imm, ALUOp 000.
  - 0100011 store: rs1, rs2 used, S-imm, ALUOp 000.
  - 1100011 branch: rs1, rs2 used, B-imm, ALUOp 001.
  - 1100111 JALR: rs1, rd used, I-imm, ALUOp 110.
  - 1101111 JAL: rd used, J-imm, ALUOp 101.
  - Unused register fields are forced to 0.
  - Any other opcode: all register fields, imm and ALUOp are 0, illegal=1. The opcode, funct3 and funct7 fields are still captured.
- Immediate forms:
  - I = sext(instr[31:20]).
  - S = sext({[31:25],[11:7]}).
  - B = sext({[31],[7],[30:25],[11:8],1'b0}).
  - U = {[31:12],12'b0}.
  - J = sext({[31],[19:12],[20],[30:21],1'b0}).
- Handshake:
  - push = valid_in & ready_in.
  - pop = valid_out & ready_out.
  - valid_out = (count != 0).
  - ready_in = !flush & ((count < DEPTH) | ready_out). When full, a same-cycle pop frees a slot; this is a combinational ready_out->ready_in path.
  - Latency: an accepted instruction appears at the outputs the cycle after acceptance at the earliest.
  - No pass-through on an empty queue.
- FIFO:
  - Push writes the decoded entry at tail; pop advances head.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged.
  - Order strictly preserved.
  - Data outputs show the head entry while count != 0, and are forced to 0 when count == 0.
- Flush:
  - Flush has priority over push and pop. Next cycle: count=0, pointers=0, valid_out=0.
  - Input presented in the flush cycle is not accepted (ready_in=0).
  - Storage contents need not be cleared.
- Holding: while valid_out=1 and ready_out=0, all outputs stay stable.
- Reset mid-operation: the queue empties immediately (asynchronously); in-flight entries are lost.

Optional Feature:
- Macro: DECODE_QUEUE_PERF_EN.
- Defined: adds outputs perf_decoded (32), perf_full_stall (32) and perf_illegal (32).
  - perf_decoded increments on each push.
  - perf_full_stall increments each cycle with valid_in=1 and ready_in=0 and flush=0.
  - perf_illegal increments on each push of an illegal opcode.
  - All three wrap at 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- addi x1,x2,5 (0x00510093), empty queue, ready_out=1 -> next cycle: valid_out=1, rs1=2, rs2=0, rd=1, imm=0x00000005, ALUOp=011, opcode=0x13, illegal=0; following cycle valid_out=0.
- addi x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF. lui x5,0x12345 (0x123452B7) -> rd=5, rs1=0, imm=0x12345000, ALUOp=100.
- DEPTH=4, ready_out=0, back-to-back valid_in with 4 instructions -> count reaches 4, ready_in=0 while ready_out=0. 5th instruction held; with ready_out=1 it is accepted in the same cycle as the first pop. Drain order equals push order, with no bubbles.
- Three entries queued, flush=1 with valid_in=1 -> ready_in=0 that cycle; next cycle count=0, valid_out=0; the new instruction was not accepted.
- 0xFFFFFFFF -> illegal=1, rs1=rs2=rd=0, imm=0, ALUOp=000, opcode=0x7F, funct7=0x7F.
- Assert reset asynchronously between clock edges with 2 entries queued -> valid_out and count drop to 0 before the next edge. With DECODE_QUEUE_PERF_EN defined, the perf counters read 0.
